// File: rtl/pmod_led_sequencer.sv
// -----------------------------------------------------------------------------
// pmod_led_sequencer
//
// Purpose:
//   Reads eight raw Pmod switches, synchronises and debounces them, and drives
//   eight active-low Pmod LEDs with one of four patterns chosen by switches 8:7
//   (sw_deb[7:6]):
//     00 PASS   - LEDs mirror the debounced switches
//     01 CHASE  - single lit LED rotating left
//     10 BOUNCE - single lit LED sweeping up and down, ends not repeated
//     11 COUNT  - 8-bit binary up-counter
//   Switches 2:1 (sw_deb[1:0]) select the step rate: one step every
//   STEP_CYCLES*(speed+1) clocks.
//
// Configuration:
//   PMOD_LED_SEQUENCER_DEBOUNCE_EN - when defined, a candidate/counter
//   debouncer requiring DEBOUNCE_CYCLES stable clocks is built in. When
//   undefined, sw_deb is a plain register of the synchronised switches
//   (3-clock input-to-sw_deb latency) and DEBOUNCE_CYCLES has no effect.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles before a switch change is accepted (>= 2)
//   STEP_CYCLES     - base prescaler period in clocks (>= 2)
//
// Ports:
//   CLK      in   1  system clock, rising edge
//   RST_N    in   1  asynchronous active-low reset
//   SWITCHES in   8  raw asynchronous switch levels, bit 0 = switch 1
//   LEDS_N   out  8  active-low LED drive, ~pattern
//   MODE     out  2  registered sequencer state
//   STEP     out  1  registered one-cycle pulse on every pattern advance
// -----------------------------------------------------------------------------
module pmod_led_sequencer #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int STEP_CYCLES     = 3000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] SWITCHES,
    output logic [7:0] LEDS_N,
    output logic [1:0] MODE,
    output logic       STEP
);

    typedef enum logic [1:0] {
        ST_PASS   = 2'b00,
        ST_CHASE  = 2'b01,
        ST_BOUNCE = 2'b10,
        ST_COUNT  = 2'b11
    } state_t;

    localparam int PRE_W = $clog2(STEP_CYCLES);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STEP_CYCLES - 1);

    // Out-of-range parameters are a configuration error; this block only
    // exists for such builds so that the range is visible in the hierarchy.
    if ((DEBOUNCE_CYCLES < 2) || (STEP_CYCLES < 2)) begin : g_param_out_of_range
    end

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    logic [7:0] sync1_r;
    logic [7:0] sync2_r;
    logic [7:0] sw_deb_r;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r <= 8'h00;
            sync2_r <= 8'h00;
        end else begin
            sync1_r <= SWITCHES;
            sync2_r <= sync1_r;
        end
    end

`ifdef PMOD_LED_SEQUENCER_DEBOUNCE_EN
    // -------------------------------------------------------------------------
    // Debouncer: one shared candidate word and one stability counter. Any bit
    // moving restarts the count for the whole word, so all eight switches are
    // accepted together once the word has been stable long enough.
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       cand_r;
    logic [CNT_W-1:0] cnt_r;

    // Candidate/counter debouncer; the counter parks at CNT_MAX while stable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cand_r   <= 8'h00;
            cnt_r    <= '0;
            sw_deb_r <= 8'h00;
        end else if (sync2_r != cand_r) begin
            cand_r <= sync2_r;
            cnt_r  <= '0;
        end else if (cnt_r == CNT_MAX) begin
            sw_deb_r <= cand_r;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end
`else
    // Debounce disabled: one register stage after the synchroniser.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_deb_r <= 8'h00;
        end else begin
            sw_deb_r <= sync2_r;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nxt_s;
    state_t           mode_req_s;
    logic [7:0]       pattern_r;
    logic [7:0]       pattern_nxt_s;
    logic [PRE_W-1:0] presc_r;
    logic [PRE_W-1:0] presc_nxt_s;
    logic [1:0]       div_r;
    logic [1:0]       div_nxt_s;
    logic [1:0]       speed_s;
    logic             dir_up_r;
    logic             dir_up_nxt_s;
    logic             step_r;
    logic             step_nxt_s;

    assign mode_req_s = state_t'(sw_deb_r[7:6]);
    assign speed_s    = sw_deb_r[1:0];

    // Next-state, entry loads, prescaler/divider and pattern advance.
    always_comb begin
        state_nxt_s   = state_r;
        pattern_nxt_s = pattern_r;
        presc_nxt_s   = presc_r;
        div_nxt_s     = div_r;
        dir_up_nxt_s  = dir_up_r;
        step_nxt_s    = 1'b0;

        if (mode_req_s != state_r) begin
            // State change: the entry load wins over any step due this cycle.
            state_nxt_s  = mode_req_s;
            presc_nxt_s  = '0;
            div_nxt_s    = 2'b00;
            dir_up_nxt_s = 1'b1;
            case (mode_req_s)
                ST_PASS:   pattern_nxt_s = sw_deb_r;
                ST_CHASE:  pattern_nxt_s = 8'h01;
                ST_BOUNCE: pattern_nxt_s = 8'h01;
                ST_COUNT:  pattern_nxt_s = 8'h00;
                default:   pattern_nxt_s = 8'h00;
            endcase
        end else if (state_r == ST_PASS) begin
            pattern_nxt_s = sw_deb_r;
            presc_nxt_s   = '0;
            div_nxt_s     = 2'b00;
        end else begin
            if (presc_r == PRE_MAX) begin
                presc_nxt_s = '0;
                // Equality test only: if speed drops below the divider it
                // simply wraps through 3 and matches on a later wrap.
                if (div_r == speed_s) begin
                    div_nxt_s  = 2'b00;
                    step_nxt_s = 1'b1;
                end else begin
                    div_nxt_s = div_r + 2'b01;
                end
            end else begin
                presc_nxt_s = presc_r + PRE_W'(1'b1);
            end

            if (step_nxt_s) begin
                case (state_r)
                    ST_CHASE: begin
                        pattern_nxt_s = {pattern_r[6:0], pattern_r[7]};
                    end
                    ST_BOUNCE: begin
                        // Turn around at the ends without repeating them.
                        if (dir_up_r) begin
                            if (pattern_r == 8'h80) begin
                                pattern_nxt_s = 8'h40;
                                dir_up_nxt_s  = 1'b0;
                            end else begin
                                pattern_nxt_s = {pattern_r[6:0], 1'b0};
                            end
                        end else begin
                            if (pattern_r == 8'h01) begin
                                pattern_nxt_s = 8'h02;
                                dir_up_nxt_s  = 1'b1;
                            end else begin
                                pattern_nxt_s = {1'b0, pattern_r[7:1]};
                            end
                        end
                    end
                    ST_COUNT: begin
                        pattern_nxt_s = pattern_r + 8'h01;
                    end
                    default: begin
                        pattern_nxt_s = pattern_r;
                    end
                endcase
            end else begin
                pattern_nxt_s = pattern_r;
            end
        end
    end

    // Sequencer state, pattern, prescaler, divider, direction and STEP pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= ST_PASS;
            pattern_r <= 8'h00;
            presc_r   <= '0;
            div_r     <= 2'b00;
            dir_up_r  <= 1'b1;
            step_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pattern_r <= pattern_nxt_s;
            presc_r   <= presc_nxt_s;
            div_r     <= div_nxt_s;
            dir_up_r  <= dir_up_nxt_s;
            step_r    <= step_nxt_s;
        end
    end

    assign LEDS_N = ~pattern_r;
    assign MODE   = state_r;
    assign STEP   = step_r;

endmodule

// File: tb/tb_pmod_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pmod_led_sequencer
//
// Scoreboard bench for pmod_led_sequencer with DEBOUNCE_CYCLES=4 and
// STEP_CYCLES=3. Stimulus pushes the expected LEDS_N/MODE (and the expected
// clock gap since the previous STEP) for each step; a monitor forked in the
// same process pops and compares whenever STEP is high. Entry loads, reset
// values and input latency are checked directly by the stimulus.
//
// Switch-to-state latency: 2 synchroniser clocks, then either 4 debounce
// clocks plus the candidate load (debounce built in) or 1 register clock,
// plus the pattern/state clock -> 8 or 4 clocks.
// -----------------------------------------------------------------------------
module tb_pmod_led_sequencer;

    localparam int DEB   = 4;
    localparam int STEPC = 3;
`ifdef PMOD_LED_SEQUENCER_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    logic       clk_s = 1'b0;
    logic       rst_n_s;
    logic [7:0] switches_s;
    logic [7:0] leds_n_s;
    logic [1:0] mode_s;
    logic       step_s;

    typedef struct {
        logic [7:0] leds;
        logic [1:0] mode;
        int         gap;
    } exp_t;

    exp_t sb_q[$];
    bit   armed_s;
    int   gap_cnt;
    int   checks;
    int   errors;

    pmod_led_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_CYCLES    (STEPC)
    ) u_dut (
        .CLK     (clk_s),
        .RST_N   (rst_n_s),
        .SWITCHES(switches_s),
        .LEDS_N  (leds_n_s),
        .MODE    (mode_s),
        .STEP    (step_s)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] pat, input logic [1:0] m, input int gap);
        exp_t e;
        e.leds = ~pat;
        e.mode = m;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    task automatic apply_sw(input logic [7:0] v);
        @(posedge clk_s);
        #1;
        switches_s = v;
    endtask

    // Land on the falling edge after n more rising edges.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_s);
        @(negedge clk_s);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(posedge clk_s);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected steps still pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [7:0] bounce_seq [15];
        int         n;
        int         d;

        bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        checks     = 0;
        errors     = 0;
        armed_s    = 1'b0;
        gap_cnt    = 0;
        rst_n_s    = 1'b0;
        switches_s = 8'h00;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk_s);
                    if (!rst_n_s) begin
                        gap_cnt = 0;
                    end else begin
                        gap_cnt++;
                        if (step_s === 1'b1) begin
                            if (armed_s) begin
                                if (sb_q.size() == 0) begin
                                    checks++;
                                    errors++;
                                    $display("FAIL unexpected_step: got STEP with leds_n %h, expected none", leds_n_s);
                                end else begin
                                    e = sb_q.pop_front();
                                    chk("step_leds", leds_n_s, e.leds);
                                    chk("step_mode", mode_s, e.mode);
                                    if (e.gap != 0) chk("step_gap", gap_cnt, e.gap);
                                end
                            end
                            gap_cnt = 0;
                        end
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk_s);
        @(negedge clk_s);
        chk("rst_leds", leds_n_s, 8'hFF);
        chk("rst_mode", mode_s, 2'b00);
        chk("rst_step", step_s, 1'b0);
        @(posedge clk_s);
        #1;
        rst_n_s = 1'b1;
        repeat (10) @(posedge clk_s);

`ifdef PMOD_LED_SEQUENCER_DEBOUNCE_EN
        // A 3-cycle 0x5A glitch never reaches the LEDs.
        apply_sw(8'h5A);
        repeat (2) @(posedge clk_s);
        apply_sw(8'h00);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_s);
            chk("glitch_leds", leds_n_s, 8'hFF);
            chk("glitch_mode", mode_s, 2'b00);
        end
`endif

        // PASS accept latency; bits 7:6 stay 00 so the LEDs mirror the switches.
        apply_sw(8'h1A);
        wait_edges(LAT - 1);
        chk("pass_before_lat", leds_n_s, 8'hFF);
        wait_edges(1);
        chk("pass_at_lat", leds_n_s, 8'hE5);
        chk("pass_mode", mode_s, 2'b00);
        repeat (6) begin
            @(negedge clk_s);
            chk("pass_no_step", step_s, 1'b0);
        end

        // CHASE, speed 0: a step every 3 clocks.
        apply_sw(8'h40);
        wait_edges(LAT);
        chk("chase_entry_leds", leds_n_s, 8'hFE);
        chk("chase_entry_mode", mode_s, 2'b01);
        armed_s = 1'b1;
        push(8'h02, 2'b01, 0);
        push(8'h04, 2'b01, 3);
        push(8'h08, 2'b01, 3);
        push(8'h10, 2'b01, 3);
        push(8'h20, 2'b01, 3);
        push(8'h40, 2'b01, 3);
        push(8'h80, 2'b01, 3);
        push(8'h01, 2'b01, 3);
        push(8'h02, 2'b01, 3);
        wait_drain("chase", 60);
        armed_s = 1'b0;

        // BOUNCE, speed 3: a step every 12 clocks, ends not repeated.
        apply_sw(8'h83);
        wait_edges(LAT);
        chk("bounce_entry_leds", leds_n_s, 8'hFE);
        chk("bounce_entry_mode", mode_s, 2'b10);
        armed_s = 1'b1;
        for (int i = 0; i < 15; i++) push(bounce_seq[i], 2'b10, (i == 0) ? 0 : 12);
        wait_drain("bounce", 220);
        armed_s = 1'b0;

        // COUNT, speed 0: 256 steps end on 0xFF then 0x00.
        apply_sw(8'hC0);
        wait_edges(LAT);
        chk("count_entry_leds", leds_n_s, 8'hFF);
        chk("count_entry_mode", mode_s, 2'b11);
        armed_s = 1'b1;
        for (int i = 1; i <= 256; i++) push(8'(i), 2'b11, (i == 1) ? 0 : 3);
        wait_drain("count", 800);
        armed_s = 1'b0;

        // Switch to CHASE so the state change lands exactly on a COUNT step.
        n = 0;
        do begin
            @(negedge clk_s);
            n++;
        end while (step_s !== 1'b1 && n < 20);
        chk("sync_step_seen", step_s, 1'b1);
        d = 3 * ((LAT + 3) / 3) - LAT;
        repeat (d - 1) @(posedge clk_s);
        apply_sw(8'h40);
        wait_edges(LAT);
        chk("collide_leds", leds_n_s, 8'hFE);
        chk("collide_mode", mode_s, 2'b01);
        chk("collide_step", step_s, 1'b0);
        armed_s = 1'b1;
        push(8'h02, 2'b01, 6);
        push(8'h04, 2'b01, 3);
        wait_drain("collide", 20);
        armed_s = 1'b0;

        // Asynchronous reset in the middle of COUNT.
        apply_sw(8'hC0);
        wait_edges(LAT + 20);
        @(posedge clk_s);
        #3;
        rst_n_s = 1'b0;
        #1;
        chk("async_rst_leds", leds_n_s, 8'hFF);
        chk("async_rst_mode", mode_s, 2'b00);
        chk("async_rst_step", step_s, 1'b0);
        repeat (3) @(posedge clk_s);
        #1;
        rst_n_s = 1'b1;
        wait_edges(LAT - 1);
        chk("post_rst_not_yet", mode_s, 2'b00);
        wait_edges(1);
        chk("post_rst_mode", mode_s, 2'b11);
        chk("post_rst_leds", leds_n_s, 8'hFF);
        armed_s = 1'b1;
        push(8'h01, 2'b11, 0);
        push(8'h02, 2'b11, 3);
        wait_drain("post_rst", 20);
        armed_s = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
